mem_access: RTL
===============

# mem_access

Load/store unit for the ECNURVCORE single-cycle datapath. It sits directly downstream of the decode control stage and consumes that stage's `load_code` and `store_code` together with the ALU-computed address and `rs2` data. It drives a req/ack data-memory bus with byte enables, returns sign- or zero-extended load data, and holds the core with `busy` until the access completes.

## Interface
- `TIMEOUT_CYC`, default 255: maximum number of cycles `mem_req` may wait for `mem_ack` before the access is aborted as a bus error (range 1–255).
- `clk`  in  1  core clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; the instruction in execute requests a memory access. Sampled in IDLE only.
- `load_code`  in  3  funct3 of the load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 111 = no load.
- `store_code`  in  2  00 SB, 01 SH, 10 SW; 11 = no store.
- `addr`  in  32  byte address from the ALU.
- `data_rs2`  in  32  store source data.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high (exclusive).
- `done`  out  1  one-cycle completion pulse.
- `rd_data`  out  32  extended load result; valid when `done` is high, held until the next accepted `start`.
- `misalign`  out  1  valid with `done`; the access was misaligned and no bus cycle was issued.
- `bus_err`  out  1  valid with `done`; the access timed out.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  store data, replicated to the byte lanes.
- `mem_ack`  in  1  bus completion; meaningful only while `mem_req` is high.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.

## Operation
- States: IDLE, REQ, RESP.
- In IDLE, a `start` pulse latches `addr`, `data_rs2` and both codes. If `load_code` is not 111, the access is a load and `store_code` is ignored. Otherwise, if `store_code` is not 11, it is a store. Otherwise it is a no-op.
- No-op → RESP: `done` is high; `rd_data`, `misalign` and `bus_err` are 0.
- Misalignment rules:
  - Halfword access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]` not 00 is misaligned.
  - Misaligned → RESP with `misalign`=1; `mem_req` is never asserted.
- Aligned access → REQ.
- In REQ, `mem_req`=1 and the address, byte enables and data are stable.
  - `mem_be`: SB/LB/LBU give `4'b0001<<addr[1:0]`; SH/LH/LHU give `4'b0011<<addr[1:0]`; word gives `4'b1111`.
  - `mem_wdata`: SB gives `{4{rs2[7:0]}}`; SH gives `{2{rs2[15:0]}}`; SW gives `rs2`.
- Load extraction uses `mem_rdata` at the ack cycle.
  - Select the byte or half by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Stores return `rd_data`=0.
- Timeout: an 8-bit counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches `TIMEOUT_CYC`, the FSM goes to RESP with `bus_err`=1 and `rd_data`=0.
- `mem_ack` on the same cycle as the timeout terminal count counts as a success.
- RESP lasts one cycle (`done`=1), then returns to IDLE.
- `start` while not in IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Reset mid-access: `mem_req` drops at the reset edge. No `done` is produced. The slave must tolerate an abandoned request.
- Ack latency is counted in cycles after `start` is sampled (cycle 0 = the `start` edge).
- Bus access, ack in the first REQ cycle: `mem_req` is high in cycle 1, `done` is high in cycle 2. Minimum latency is 2 cycles.
- Bus access, ack in REQ cycle *k* (1-based): `done` is high in cycle k+1.
- Misaligned or no-op: `done` is high in cycle 1 and `busy` never asserts.
- All outputs are registered; there is no combinational path from `mem_ack` to `mem_req`.

## Structure
- Shared package `ecnu_pkg` holds:
  - load codes: LD_B, LD_H, LD_W, LD_BU, LD_HU, LD_NONE=3'b111
  - store codes: ST_B, ST_H, ST_W, ST_NONE=2'b11
  - the FSM state enum
- The code encodings match the decode control stage exactly.
- One combinational sub-module, `load_extend` (`rdata`, `addr[1:0]`, `load_code` → 32-bit result), is used at the ack cycle.

## Test plan
- LB at `addr`=0x1003, `mem_rdata`=0x80AB_CDEF, ack in the first REQ cycle → `mem_be`=1000, `mem_addr`=0x1000, `rd_data`=0xFFFF_FF80, `done` in cycle 2.
- LHU at 0x2002, `mem_rdata`=0x8001_1234, ack after 3 wait cycles → `rd_data`=0x0000_8001, `done` in cycle 5, `busy` high in cycles 1–4.
- SB at 0x3001, `rs2`=0x1234_56A5 → `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xA5A5_A5A5; SW at 0x3000 → `mem_be`=1111.
- LW at 0x4002 → `misalign`=1, `done` in cycle 1, `mem_req` never high. No-op (`load_code`=111, `store_code`=11) → `done` in cycle 1, all flags 0.
- `TIMEOUT_CYC`=4, no ack → `mem_req` high for exactly 4 cycles, then `done`=1, `bus_err`=1, `rd_data`=0. A second `start` issued during the wait is ignored.
- `rst` asserted in the second REQ cycle → `mem_req`=0 and `busy`=0 next cycle, no `done`. A fresh LW at 0x0 then completes normally.

Source files
------------

// File: rtl/ecnu_pkg.sv
// ---------------------------------------------------------------------------
// ecnu_pkg
// Shared definitions for the ECNURVCORE datapath: load/store code encodings
// (identical to the decode control stage), the load/store unit FSM state
// type, an access-size type and small helpers that turn a size plus byte
// offset into byte enables, lane-replicated store data and an alignment
// verdict.
// ---------------------------------------------------------------------------
package ecnu_pkg;

    // Load codes (funct3 of the load instruction).
    localparam logic [2:0] LD_B    = 3'b000;
    localparam logic [2:0] LD_H    = 3'b001;
    localparam logic [2:0] LD_W    = 3'b010;
    localparam logic [2:0] LD_BU   = 3'b100;
    localparam logic [2:0] LD_HU   = 3'b101;
    localparam logic [2:0] LD_NONE = 3'b111;

    // Store codes.
    localparam logic [1:0] ST_B    = 2'b00;
    localparam logic [1:0] ST_H    = 2'b01;
    localparam logic [1:0] ST_W    = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    // Load/store unit FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10
    } mem_state_e;

    // Width of a memory access.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_e;

    // Size of a load from the low two funct3 bits; the unused encodings
    // 011/110 fall into the word bucket.
    function automatic access_size_e load_size(input logic [1:0] code_lo);
        access_size_e sz;
        case (code_lo)
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Size of a store from its code.
    function automatic access_size_e store_size(input logic [1:0] code);
        access_size_e sz;
        case (code)
            ST_B:    sz = SZ_BYTE;
            ST_H:    sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input access_size_e sz,
                                           input logic [1:0]   off);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Byte enables for an aligned access at the given offset.
    function automatic logic [3:0] byte_enables(input access_size_e sz,
                                                input logic [1:0]   off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every byte lane the access could hit,
    // so the slave only needs the byte enables to pick the right lanes.
    function automatic logic [31:0] store_lanes(input access_size_e sz,
                                                input logic [31:0]  data);
        logic [31:0] lanes;
        case (sz)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load result formatter. Picks the byte or halfword addressed
// by the low address bits out of the bus word and sign- or zero-extends it
// according to the load code; word loads pass straight through.
//   rdata     in  32  word returned by the data bus
//   off       in  2   byte offset (addr[1:0]) of the access
//   load_code in  3   funct3 of the load
//   result    out 32  extended load value
// ---------------------------------------------------------------------------
module load_extend
    import ecnu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  load_code,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: byte by the full offset, halfword by offset bit 1.
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension of the selected lane according to the load flavour.
    always_comb begin
        result = 32'h0000_0000;
        case (load_code)
            LD_B:    result = {{24{byte_s[7]}}, byte_s};
            LD_H:    result = {{16{half_s[15]}}, half_s};
            LD_BU:   result = {24'h00_0000, byte_s};
            LD_HU:   result = {16'h0000, half_s};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Load/store unit of the ECNURVCORE single-cycle datapath. Accepts a
// one-cycle start from execute, classifies it as load / store / no-op,
// rejects misaligned accesses without touching the bus, otherwise runs one
// req/ack bus cycle with a wait-cycle timeout, and reports completion with a
// one-cycle done pulse. Every output comes straight from a flop.
//   clk, rst                 core clock, synchronous active-high reset
//   start                    access request (only honoured in IDLE)
//   load_code, store_code    decode control codes (111 / 11 = none)
//   addr, data_rs2           byte address and store data
//   busy, done               core stall and completion pulse
//   rd_data                  extended load result (held after done)
//   misalign, bus_err        completion status, valid with done
//   mem_req/we/be/addr/wdata data bus request side
//   mem_ack, mem_rdata       data bus response side
// ---------------------------------------------------------------------------
module mem_access
    import ecnu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  load_code,
    input  logic [1:0]  store_code,
    input  logic [31:0] addr,
    input  logic [31:0] data_rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Number of unacknowledged REQ cycles that ends the access.
    localparam logic [8:0] TMO_LAST = 9'(TIMEOUT_CYC);

    mem_state_e   state_q,     state_d;
    logic [7:0]   cnt_q,       cnt_d;
    logic         is_load_q,   is_load_d;
    logic [2:0]   ld_code_q,   ld_code_d;
    logic [1:0]   off_q,       off_d;
    logic         busy_q,      busy_d;
    logic         done_q,      done_d;
    logic [31:0]  rd_data_q,   rd_data_d;
    logic         misalign_q,  misalign_d;
    logic         bus_err_q,   bus_err_d;
    logic         mem_req_q,   mem_req_d;
    logic         mem_we_q,    mem_we_d;
    logic [3:0]   mem_be_q,    mem_be_d;
    logic [31:0]  mem_addr_q,  mem_addr_d;
    logic [31:0]  mem_wdata_q, mem_wdata_d;

    logic         is_load_s;
    logic         is_store_s;
    access_size_e size_s;
    logic         misaligned_s;
    logic         timeout_s;
    logic [31:0]  ext_s;

    // Load formatting of the bus word, used on the ack cycle.
    load_extend u_load_extend (
        .rdata     (mem_rdata),
        .off       (off_q),
        .load_code (ld_code_q),
        .result    (ext_s)
    );

    // Classify the incoming request: a load code wins over a store code.
    always_comb begin
        is_load_s  = (load_code != LD_NONE);
        is_store_s = (!is_load_s) && (store_code != ST_NONE);
        if (is_load_s) begin
            size_s = load_size(load_code[1:0]);
        end else begin
            size_s = store_size(store_code);
        end
        misaligned_s = (is_load_s || is_store_s) && is_misaligned(size_s, addr[1:0]);
        timeout_s    = (({1'b0, cnt_q} + 9'd1) == TMO_LAST);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        ld_code_d   = ld_code_q;
        off_d       = off_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_data_d   = rd_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_data_d = 32'h0000_0000;
                    if (!is_load_s && !is_store_s) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                    end else if (misaligned_s) begin
                        state_d    = S_RESP;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        cnt_d      = 8'd0;
                        is_load_d  = is_load_s;
                        ld_code_d  = load_code;
                        off_d      = addr[1:0];
                        busy_d     = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = is_store_s;
                        mem_be_d   = byte_enables(size_s, addr[1:0]);
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (is_store_s) begin
                            mem_wdata_d = store_lanes(size_s, data_rs2);
                        end else begin
                            mem_wdata_d = 32'h0000_0000;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_REQ: begin
                // An ack on the terminal-count cycle still counts as success.
                if (mem_ack || timeout_s) begin
                    state_d     = S_RESP;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b0000;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wdata_d = 32'h0000_0000;
                    if (mem_ack && is_load_q) begin
                        rd_data_d = ext_s;
                    end else begin
                        rd_data_d = 32'h0000_0000;
                    end
                    bus_err_d = !mem_ack;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            is_load_q   <= 1'b0;
            ld_code_q   <= 3'b000;
            off_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= 32'h0000_0000;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            ld_code_q   <= ld_code_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
